// File: rtl/morse_src_arbiter.sv
// N-source Morse key arbiter: grants one key source, forwards its key through a
// DELAY-stage line, and pulses the decoder reset when ownership moves between sources.
module morse_src_arbiter #(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned DELAY    = 5,
  parameter int unsigned RST_LEN  = 2,
  parameter int unsigned IDLE_CYC = 1000000,
  parameter int unsigned MODE     = 0
) (
  input  logic             clk,
  input  logic             ext_rst,
  input  logic [N_SRC-1:0] key_in,
  output logic             rst_out,
  output logic             d_out,
  output logic [N_SRC-1:0] owner,
  output logic             owner_valid
);

  localparam int unsigned     IW         = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
  localparam int unsigned     PW         = $clog2(RST_LEN + 1);
  localparam logic [IW-1:0]   IDLE_LAST  = IW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
  localparam logic [PW-1:0]   PULSE_LOAD = PW'(RST_LEN);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t           r_state, w_state_next;
  logic [N_SRC-1:0] r_owner, w_owner_next;
  logic [N_SRC-1:0] w_lowest;
  logic [N_SRC-1:0] w_lower_mask;
  logic [IW-1:0]    r_idle_cnt, w_idle_next;
  logic [PW-1:0]    r_pulse_cnt, w_pulse_next;
  logic [DELAY-1:0] r_dly, w_dly_next;
  logic             w_found;
  logic             w_switch;
  logic             w_draw;
  logic             w_own_key;
  logic             w_preempt;

  // One-hot of the lowest-index asserted key.
  always_comb begin
    w_lowest = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (key_in[i] && !w_found) begin
        w_lowest[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign w_own_key    = |(key_in & r_owner);
  assign w_lower_mask = r_owner - N_SRC'(1);
  assign w_preempt    = (MODE == 1) && (|(key_in & w_lower_mask));

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_idle_next  = r_idle_cnt;
    w_switch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle_next = '0;
        if (|key_in) begin
          w_state_next = ST_OWNED;
          w_owner_next = w_lowest;
        end
      end
      ST_OWNED: begin
        // Release takes precedence over pre-emption; a press in the release
        // cycle is re-evaluated from IDLE and therefore fires no pulse.
        if (IDLE_CYC == 0 || w_own_key) begin
          w_idle_next = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_next = ST_IDLE;
          w_owner_next = '0;
          w_idle_next  = '0;
        end else if (r_idle_cnt != '1) begin
          w_idle_next = r_idle_cnt + IW'(1);
        end
        if (w_state_next == ST_OWNED && w_preempt) begin
          w_owner_next = w_lowest;
          w_switch     = 1'b1;
          w_idle_next  = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_owner_next = '0;
        w_idle_next  = '0;
      end
    endcase
  end

  assign w_draw = |(key_in & w_owner_next);

  always_comb begin
    w_pulse_next = r_pulse_cnt;
    if (w_switch) begin
      w_pulse_next = PULSE_LOAD;
    end else if (r_pulse_cnt != '0) begin
      w_pulse_next = r_pulse_cnt - PW'(1);
    end
  end

  // A switch flushes the previous owner's tail but still captures the new owner's first sample.
  always_comb begin
    w_dly_next    = '0;
    w_dly_next[0] = w_draw;
    for (int unsigned i = 1; i < DELAY; i++) begin
      w_dly_next[i] = w_switch ? 1'b0 : r_dly[i-1];
    end
  end

  always_ff @(posedge clk or posedge ext_rst) begin
    if (ext_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_idle_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_dly       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_idle_cnt  <= w_idle_next;
      r_pulse_cnt <= w_pulse_next;
      r_dly       <= w_dly_next;
    end
  end

  assign rst_out     = ext_rst | (r_pulse_cnt != '0);
  assign d_out       = r_dly[DELAY-1];
  assign owner       = r_owner;
  assign owner_valid = (r_state == ST_OWNED);

endmodule

// File: tb/tb_morse_src_arbiter.sv
// Scoreboard bench for morse_src_arbiter: MODE 0 instance (A) and MODE 1 instance (B),
// both N_SRC=4, DELAY=5, RST_LEN=2, IDLE_CYC=8.
module tb_morse_src_arbiter;

  logic       clk = 1'b0;
  logic       ext_rst;
  logic [3:0] key_a, key_b;
  logic       rst_a, d_a, val_a;
  logic       rst_b, d_b, val_b;
  logic [3:0] own_a, own_b;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    bit         dut;
    int         idx;
    logic [3:0] own;
    logic       v;
    logic       r;
    logic       d;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  morse_src_arbiter #(.N_SRC(4), .DELAY(5), .RST_LEN(2), .IDLE_CYC(8), .MODE(0)) u_a (
    .clk(clk), .ext_rst(ext_rst), .key_in(key_a), .rst_out(rst_a),
    .d_out(d_a), .owner(own_a), .owner_valid(val_a)
  );

  morse_src_arbiter #(.N_SRC(4), .DELAY(5), .RST_LEN(2), .IDLE_CYC(8), .MODE(1)) u_b (
    .clk(clk), .ext_rst(ext_rst), .key_in(key_b), .rst_out(rst_b),
    .d_out(d_b), .owner(own_b), .owner_valid(val_b)
  );

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic sa(input logic [3:0] k, input logic [3:0] o, input logic v, input logic r, input logic d);
    exp_t e;
    @(negedge clk);
    key_a = k;
    key_b = '0;
    e.dut = 1'b0; e.idx = step_no; e.own = o; e.v = v; e.r = r; e.d = d;
    sbq.push_back(e);
    step_no++;
  endtask

  task automatic sb(input logic [3:0] k, input logic [3:0] o, input logic v, input logic r, input logic d);
    exp_t e;
    @(negedge clk);
    key_a = '0;
    key_b = k;
    e.dut = 1'b1; e.idx = step_no; e.own = o; e.v = v; e.r = r; e.d = d;
    sbq.push_back(e);
    step_no++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sbq.size());
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.dut == 1'b0) begin
          check("A.owner", e.idx, own_a, e.own);
          check("A.valid", e.idx, {3'b000, val_a}, {3'b000, e.v});
          check("A.rst_out", e.idx, {3'b000, rst_a}, {3'b000, e.r});
          check("A.d_out", e.idx, {3'b000, d_a}, {3'b000, e.d});
        end else begin
          check("B.owner", e.idx, own_b, e.own);
          check("B.valid", e.idx, {3'b000, val_b}, {3'b000, e.v});
          check("B.rst_out", e.idx, {3'b000, rst_b}, {3'b000, e.r});
          check("B.d_out", e.idx, {3'b000, d_b}, {3'b000, e.d});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ext_rst = 1'b1;
    key_a   = '0;
    key_b   = '0;
    #2;
    check("rst.A.rst_out", -1, {3'b000, rst_a}, 4'b0001);
    check("rst.A.owner", -1, own_a, 4'b0000);
    check("rst.A.valid", -1, {3'b000, val_a}, 4'b0000);
    check("rst.A.d_out", -1, {3'b000, d_a}, 4'b0000);
    check("rst.B.rst_out", -1, {3'b000, rst_b}, 4'b0001);
    check("rst.B.owner", -1, own_b, 4'b0000);
    repeat (2) @(negedge clk);
    ext_rst = 1'b0;

    // A: acquire key 2, d_out follows 5 cycles later, release after 8 low cycles
    repeat (2) sa(4'b0000, 4'b0000, 0, 0, 0);
    repeat (3) sa(4'b0100, 4'b0100, 1, 0, 0);
    sa(4'b0000, 4'b0100, 1, 0, 0);
    repeat (3) sa(4'b0000, 4'b0100, 1, 0, 1);
    repeat (3) sa(4'b0000, 4'b0100, 1, 0, 0);
    repeat (4) sa(4'b0000, 4'b0000, 0, 0, 0);

    // A: simultaneous press, key 3 ignored, release with key 3 pressed on that cycle
    sa(4'b1010, 4'b0010, 1, 0, 0);
    sa(4'b1000, 4'b0010, 1, 0, 0);
    sa(4'b1000, 4'b0010, 1, 0, 0);
    sa(4'b0000, 4'b0010, 1, 0, 0);
    sa(4'b1000, 4'b0010, 1, 0, 1);
    repeat (3) sa(4'b0000, 4'b0010, 1, 0, 0);
    sa(4'b1000, 4'b0000, 0, 0, 0);
    sa(4'b1000, 4'b1000, 1, 0, 0);
    repeat (3) sa(4'b0000, 4'b1000, 1, 0, 0);
    sa(4'b0000, 4'b1000, 1, 0, 1);
    sa(4'b0000, 4'b1000, 1, 0, 0);

    // B: pre-emption 2 -> 0, pulse for 2 cycles, line flushed, key 3 ignored
    sb(4'b0000, 4'b0000, 0, 0, 0);
    repeat (2) sb(4'b0100, 4'b0100, 1, 0, 0);
    repeat (2) sb(4'b0001, 4'b0001, 1, 1, 0);
    sb(4'b1001, 4'b0001, 1, 0, 0);
    sb(4'b0000, 4'b0001, 1, 0, 0);
    repeat (3) sb(4'b0000, 4'b0001, 1, 0, 1);
    repeat (3) sb(4'b0000, 4'b0001, 1, 0, 0);
    sb(4'b0000, 4'b0000, 0, 0, 0);

    // B: back-to-back switches 2 -> 1 -> 0 hold rst_out high continuously
    sb(4'b0100, 4'b0100, 1, 0, 0);
    sb(4'b0110, 4'b0010, 1, 1, 0);
    sb(4'b0111, 4'b0001, 1, 1, 0);
    sb(4'b0001, 4'b0001, 1, 1, 0);
    repeat (2) sb(4'b0000, 4'b0001, 1, 0, 0);
    repeat (2) sb(4'b0000, 4'b0001, 1, 0, 1);
    sb(4'b0000, 4'b0001, 1, 0, 0);
    drain();

    // Asynchronous reset between edges
    @(negedge clk);
    ext_rst = 1'b1;
    #1;
    check("arst1.B.owner", -2, own_b, 4'b0000);
    check("arst1.B.valid", -2, {3'b000, val_b}, 4'b0000);
    check("arst1.B.rst_out", -2, {3'b000, rst_b}, 4'b0001);
    @(negedge clk);
    ext_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_a = 4'b0001;
      key_b = (i < 4) ? 4'b0100 : 4'b0001;
    end
    @(posedge clk);
    #3;
    check("pre.A.d_out", -3, {3'b000, d_a}, 4'b0001);
    check("pre.A.rst_out", -3, {3'b000, rst_a}, 4'b0000);
    check("pre.B.owner", -3, own_b, 4'b0001);
    check("pre.B.rst_out", -3, {3'b000, rst_b}, 4'b0001);
    ext_rst = 1'b1;
    #1;
    check("arst2.A.d_out", -4, {3'b000, d_a}, 4'b0000);
    check("arst2.A.owner", -4, own_a, 4'b0000);
    check("arst2.A.valid", -4, {3'b000, val_a}, 4'b0000);
    check("arst2.A.rst_out", -4, {3'b000, rst_a}, 4'b0001);
    check("arst2.B.owner", -4, own_b, 4'b0000);
    check("arst2.B.valid", -4, {3'b000, val_b}, 4'b0000);
    check("arst2.B.rst_out", -4, {3'b000, rst_b}, 4'b0001);
    @(negedge clk);
    ext_rst = 1'b0;
    key_a   = '0;
    key_b   = '0;

    // A: normal acquisition after reset
    sa(4'b0000, 4'b0000, 0, 0, 0);
    sa(4'b0010, 4'b0010, 1, 0, 0);
    repeat (3) sa(4'b0000, 4'b0010, 1, 0, 0);
    sa(4'b0000, 4'b0010, 1, 0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_src_arbiter.md
Name: morse_src_arbiter

Overview:
- Parametrised N-source Morse key arbiter. Successor to the two-input key source selector.
- Grants one key source ownership and forwards only that key through a configurable delay line to the Morse decoder.
- Pulses a downstream decoder reset when ownership moves between sources.
- Releases ownership after a programmable idle period, or allows priority pre-emption in mode 1.

Parameters:
- N_SRC, 4: number of key sources; minimum 2.
- DELAY, 5: d_out pipeline depth in cycles; minimum 1.
- RST_LEN, 2: switch-reset pulse length in cycles; minimum 1.
- IDLE_CYC, 1000000: consecutive owner-key-low cycles before release; 0 disables release.
- MODE, 0: 0 = first-come hold (no pre-emption); 1 = fixed priority, where the lower index pre-empts.

Ports:
- clk  in  1  system clock
- ext_rst  in  1  asynchronous active-high reset
- key_in  in  N_SRC  synchronised, debounced key levels; bit i is source i
- rst_out  out  1  decoder reset = ext_rst OR switch pulse
- d_out  out  1  owner key level, delayed DELAY cycles
- owner  out  N_SRC  one-hot current owner; all zero when idle
- owner_valid  out  1  high while any source owns the channel

Behaviour:
- Reset: ext_rst is asynchronous, active-high; clock clk. While ext_rst is high:
  - owner = 0, owner_valid = 0.
  - Delay line is all 0, so d_out = 0.
  - Idle counter = 0, pulse counter = 0.
  - rst_out = 1.
- States: IDLE (owner_valid = 0) and OWNED (owner_valid = 1).
- IDLE:
  - Any key_in bit high -> OWNED at the next edge.
  - owner = lowest-index asserted bit. Multiple simultaneous presses: lowest index wins.
  - Acquisition from IDLE does NOT fire a switch pulse.
- OWNED, MODE 0:
  - Non-owner keys are ignored.
  - Owner key high -> idle counter cleared; owner key low -> idle counter increments.
  - Owner key low with counter == IDLE_CYC-1 -> release to IDLE at that edge. Net effect: release after IDLE_CYC consecutive low cycles.
- OWNED, MODE 1:
  - Same idle/release rule as MODE 0.
  - Any asserted key with index lower than the owner -> owner becomes the lowest asserted index at the next edge.
  - This is a switch: fire the pulse and clear the idle counter.
  - Higher-index keys are ignored.
- Release and a new press on the same cycle: release wins; the new press is evaluated from IDLE on the following cycle, so no pulse fires.
- IDLE_CYC = 0: counter held at 0; no release. MODE 0 then owns forever until ext_rst.
- Switch pulse:
  - At the edge where owner changes between two non-zero values, load the pulse counter with RST_LEN.
  - rst_out is high for RST_LEN cycles starting that cycle (combinational from the counter, no extra latency).
  - A new switch while the pulse is active reloads the counter to RST_LEN.
- Data path:
  - d_raw = OR(key_in AND owner_next), where owner_next is the combinational next-state owner. The first press of a new owner is therefore not lost.
  - d_raw shifts into a DELAY-stage register; d_out = last stage.
  - Latency from key_in to d_out is exactly DELAY cycles.
  - On a switch edge, the whole delay line is cleared to 0 so the decoder is not fed the previous source's tail. The new owner's d_raw enters stage 1 at the next edge.
  - Release does not clear the delay line; it drains naturally.
- Width rules:
  - Idle counter width = clog2(IDLE_CYC+1), saturating, never wraps.
  - Pulse counter width = clog2(RST_LEN+1).
- owner is always one-hot or zero; never multi-hot.

Test Plan:
- Reset/acquire: ext_rst pulse -> all outputs 0, rst_out 1. Then N_SRC=4, DELAY=5: key_in = 4'b0100 at cycle 10 -> owner = 4'b0100 at cycle 11, d_out high at cycle 15, rst_out stays 0.
- Simultaneous acquire: key_in = 4'b1010 from IDLE -> owner = 4'b0010, no pulse. key 3 pulses are never seen on d_out (MODE 0).
- Idle release: IDLE_CYC = 8, owner bit 1 released at cycle 20 -> owner_valid drops exactly 8 cycles later. Key 3 pressed in that release cycle -> owner = 4'b1000 one cycle later, no pulse.
- Pre-emption (MODE 1, RST_LEN = 2): owner = bit 2; key 0 pressed -> owner = 4'b0001 next edge. rst_out high for exactly 2 cycles, delay line zeroed, key 0 appears on d_out after DELAY cycles. key 3 press -> ignored.
- Back-to-back switch (MODE 1): bit 2 -> bit 1 -> bit 0 on consecutive edges -> rst_out held high continuously, dropping 2 cycles after the last switch.
- Async reset mid-operation: ext_rst asserted between clock edges while a pulse is active and d_out = 1 -> outputs go to their reset values immediately without waiting for a clock edge. Normal acquisition resumes after deassertion.
